opex_stage: RTL
===============

OPEX_STAGE -- requirements
Module: opex_stage

Interface
REQ-001 SHALL have parameter: none; all widths come from p_hardisc types (rf_add, ictrl, f_part).
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 s_clk_i  in  1  pipeline clock, all state on rising edge.
REQ-004 s_reset_i  in  1  synchronous active-high reset.
REQ-005 s_stall_i  in  1  EX stage cannot accept; hold register contents.
REQ-006 s_flush_i  in  1  kill instruction held in/entering EX.
REQ-007 s_bubble_i  in  1  OP-stage bubble request; load NOP instead of OP instruction.
REQ-008 s_operand1_i, s_operand2_i  in  32 each  prepared operands from OP.
REQ-009 s_fwd_i  in  4  forwarding flags: [0] op1<-MA, [1] op2<-MA, [2] op1<-WB, [3] op2<-WB.
REQ-010 s_rd_i  in  rf_add; s_ictrl_i  in  ictrl; s_f_i  in  f_part; s_payload_i  in  21  OP instruction fields.
REQ-011 s_exma_val_i, s_mawb_val_i  in  32 each  current MA-stage and WB-stage results.
REQ-012 s_opex_op1_o, s_opex_op2_o  out  32 each  forwarding-resolved EX operands.
REQ-013 s_opex_rd_o, s_opex_ictrl_o, s_opex_f_o, s_opex_payload_o  out  registered instruction fields.
REQ-014 s_opex_valid_o  out  1  EX holds a real instruction.

Function
REQ-015 Update priority per edge: reset > flush > stall > bubble > load.
REQ-016 Load (no stall, no bubble, no flush): capture all OP inputs; valid=1; one-cycle latency OP->EX.
REQ-017 Bubble: valid=0, ictrl=0, fwd=0, rd=0, operands=0.
REQ-018 Flush: same state as bubble; flush during stall overrides hold.
REQ-019 Operand resolution (combinational from registers): op1 = fwd[0] ? exma_val : fwd[2] ? mawb_val : stored op1; op2 likewise with fwd[1]/fwd[3]; MA flag wins over WB.
REQ-020 Stall: first stalled cycle writes resolved op1/op2 back into operand registers and clears fwd; subsequent stall cycles hold unchanged, so MA/WB advancing during stall cannot corrupt operands.
REQ-021 Stall with fwd=0: operands and fields held bit-exact.
REQ-022 Stall release: next edge loads OP inputs (or bubble) normally.
REQ-023 All outputs other than op1/op2 are direct register outputs.

Reset
REQ-024 On reset all registers 0: valid=0, ictrl=0 (NOP), fwd=0, rd=0, operands=0, payload=0, f=0.
REQ-025 Reset asserted mid-stall discards held instruction.

Configuration
REQ-026 Macro OPEX_PARITY_EN: with it, one even-parity bit per stored operand, computed on every operand-register write (load and stall write-back); output s_opex_perr_o (1 bit) = valid & parity mismatch on either operand register.
REQ-027 Without OPEX_PARITY_EN: no parity bits, no s_opex_perr_o port; otherwise identical.

Structure
REQ-028 rf_add, ictrl, f_part, ICTRL_* indices shared via p_hardisc; add OPEX_FWD_* bit-index constants there.
REQ-029 One sub-module natural: opex_fwd_mux (per-operand 3-way resolution), instantiated twice.

Verification
REQ-030 Load op1=0x11, op2=0x22, fwd=0 -> next cycle op1=0x11, op2=0x22, valid=1.
REQ-031 Load fwd=4'b0101, exma_val=0xAAAA0000, mawb_val=0x5555 -> op1=0xAAAA0000 (MA wins), op2=stored.
REQ-032 Load fwd=4'b0001, stall 3 cycles, exma_val changes 0x10->0x20 on stall cycle 2 -> op1 stays 0x10, fwd reads 0.
REQ-033 s_bubble_i=1 with valid OP inputs -> valid=0, ictrl=0; flush during stall -> valid=0 next cycle.
REQ-034 Reset mid-stall -> all outputs 0 next edge.
REQ-035 OPEX_PARITY_EN: force flip of stored op2 bit 7 -> s_opex_perr_o=1 while valid; bubble -> 0.

Source files
------------

// File: rtl/opex_stage_pkg.sv
// ---------------------------------------------------------------------------
// p_hardisc : types and index constants shared across the core pipeline.
//   rf_add  - register-file address
//   ictrl   - instruction control vector (all-zero encodes a NOP)
//   f_part  - function/funct3 part of the instruction
//   OPEX_FWD_* - bit positions inside the OP->EX forwarding flag vector
// ---------------------------------------------------------------------------
package p_hardisc;

    typedef logic [4:0] rf_add;
    typedef logic [6:0] ictrl;
    typedef logic [2:0] f_part;

    localparam int ICTRL_UNIT_ALU = 0;
    localparam int ICTRL_UNIT_BRU = 1;
    localparam int ICTRL_UNIT_LSU = 2;
    localparam int ICTRL_UNIT_CSR = 3;
    localparam int ICTRL_UNIT_MDU = 4;
    localparam int ICTRL_REG_DEST = 5;
    localparam int ICTRL_RVC      = 6;

    localparam int OPEX_FWD_OP1_MA = 0;
    localparam int OPEX_FWD_OP2_MA = 1;
    localparam int OPEX_FWD_OP1_WB = 2;
    localparam int OPEX_FWD_OP2_WB = 3;

    // Even parity bit: set when the word holds an odd number of ones,
    // so word + parity bit always carries an even count.
    function automatic logic even_parity(input logic [31:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/opex_stage_fwd_mux.sv
// ---------------------------------------------------------------------------
// opex_fwd_mux : resolves one EX operand from the stored value or a
// forwarded MA/WB result. MA is the younger result and wins over WB.
//   s_stored_i  in  32  operand held in the OP/EX register
//   s_ma_i      in  32  current MA-stage result
//   s_wb_i      in  32  current WB-stage result
//   s_sel_ma_i  in  1   take MA result
//   s_sel_wb_i  in  1   take WB result (ignored when s_sel_ma_i is set)
//   s_res_o     out 32  resolved operand
// ---------------------------------------------------------------------------
module opex_fwd_mux (
    input  logic [31:0] s_stored_i,
    input  logic [31:0] s_ma_i,
    input  logic [31:0] s_wb_i,
    input  logic        s_sel_ma_i,
    input  logic        s_sel_wb_i,
    output logic [31:0] s_res_o
);

    always_comb begin
        if (s_sel_ma_i)
            s_res_o = s_ma_i;
        else if (s_sel_wb_i)
            s_res_o = s_wb_i;
        else
            s_res_o = s_stored_i;
    end

endmodule

// File: rtl/opex_stage.sv
// ---------------------------------------------------------------------------
// opex_stage : OP->EX pipeline register with late operand forwarding.
// Operands are resolved combinationally from the stored values and the live
// MA/WB results. On the first stall cycle the resolved operands are written
// back and the forwarding flags cleared, so results moving on during a stall
// cannot corrupt the held operands.
//
// Ports:
//   s_clk_i, s_reset_i                clock, synchronous active-high reset
//   s_stall_i, s_flush_i, s_bubble_i  hold / kill / insert-NOP controls
//   s_operand1_i, s_operand2_i        operands from OP
//   s_fwd_i                           forwarding flags (OPEX_FWD_* indices)
//   s_rd_i, s_ictrl_i, s_f_i, s_payload_i  OP instruction fields
//   s_exma_val_i, s_mawb_val_i        current MA / WB results
//   s_opex_op1_o, s_opex_op2_o        resolved EX operands
//   s_opex_rd_o, s_opex_ictrl_o, s_opex_f_o, s_opex_payload_o  registered fields
//   s_opex_valid_o                    EX holds a real instruction
//   s_opex_perr_o                     operand parity error (OPEX_PARITY_EN only)
//
// Build option: define OPEX_PARITY_EN to add one even-parity bit per stored
// operand and the s_opex_perr_o output.
// ---------------------------------------------------------------------------
module opex_stage
    import p_hardisc::*;
(
    input  logic        s_clk_i,
    input  logic        s_reset_i,
    input  logic        s_stall_i,
    input  logic        s_flush_i,
    input  logic        s_bubble_i,
    input  logic [31:0] s_operand1_i,
    input  logic [31:0] s_operand2_i,
    input  logic [3:0]  s_fwd_i,
    input  rf_add       s_rd_i,
    input  ictrl        s_ictrl_i,
    input  f_part       s_f_i,
    input  logic [20:0] s_payload_i,
    input  logic [31:0] s_exma_val_i,
    input  logic [31:0] s_mawb_val_i,
    output logic [31:0] s_opex_op1_o,
    output logic [31:0] s_opex_op2_o,
    output rf_add       s_opex_rd_o,
    output ictrl        s_opex_ictrl_o,
    output f_part       s_opex_f_o,
    output logic [20:0] s_opex_payload_o,
`ifdef OPEX_PARITY_EN
    output logic        s_opex_perr_o,
`endif
    output logic        s_opex_valid_o
);

    logic        valid_q, valid_d;
    rf_add       rd_q, rd_d;
    ictrl        ictrl_q, ictrl_d;
    f_part       f_q, f_d;
    logic [20:0] payload_q, payload_d;
    logic [3:0]  fwd_q, fwd_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [31:0] op1_res, op2_res;

    opex_fwd_mux u_fwd_op1 (
        .s_stored_i (op1_q),
        .s_ma_i     (s_exma_val_i),
        .s_wb_i     (s_mawb_val_i),
        .s_sel_ma_i (fwd_q[OPEX_FWD_OP1_MA]),
        .s_sel_wb_i (fwd_q[OPEX_FWD_OP1_WB]),
        .s_res_o    (op1_res)
    );

    opex_fwd_mux u_fwd_op2 (
        .s_stored_i (op2_q),
        .s_ma_i     (s_exma_val_i),
        .s_wb_i     (s_mawb_val_i),
        .s_sel_ma_i (fwd_q[OPEX_FWD_OP2_MA]),
        .s_sel_wb_i (fwd_q[OPEX_FWD_OP2_WB]),
        .s_res_o    (op2_res)
    );

    always_comb begin
        valid_d   = valid_q;
        rd_d      = rd_q;
        ictrl_d   = ictrl_q;
        f_d       = f_q;
        payload_d = payload_q;
        fwd_d     = fwd_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        if (s_flush_i || (!s_stall_i && s_bubble_i)) begin
            // Flush beats stall; flush and bubble both leave a clean NOP.
            valid_d   = 1'b0;
            rd_d      = '0;
            ictrl_d   = '0;
            f_d       = '0;
            payload_d = '0;
            fwd_d     = '0;
            op1_d     = '0;
            op2_d     = '0;
        end else if (s_stall_i) begin
            // Only the first stall cycle has flags set; capture the
            // forwarded values then and hold bit-exact afterwards.
            if (fwd_q != 4'b0000) begin
                op1_d = op1_res;
                op2_d = op2_res;
                fwd_d = '0;
            end
        end else begin
            valid_d   = 1'b1;
            rd_d      = s_rd_i;
            ictrl_d   = s_ictrl_i;
            f_d       = s_f_i;
            payload_d = s_payload_i;
            fwd_d     = s_fwd_i;
            op1_d     = s_operand1_i;
            op2_d     = s_operand2_i;
        end
    end

    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            valid_q   <= 1'b0;
            rd_q      <= '0;
            ictrl_q   <= '0;
            f_q       <= '0;
            payload_q <= '0;
            fwd_q     <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            rd_q      <= rd_d;
            ictrl_q   <= ictrl_d;
            f_q       <= f_d;
            payload_q <= payload_d;
            fwd_q     <= fwd_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
        end
    end

`ifdef OPEX_PARITY_EN
    logic par1_q, par2_q;
    logic op_wr;

    // Parity follows every operand-register write; holds keep the old bit
    // so a corrupted stored operand stays detectable.
    assign op_wr = s_flush_i || !s_stall_i || (fwd_q != 4'b0000);

    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            par1_q <= 1'b0;
            par2_q <= 1'b0;
        end else if (op_wr) begin
            par1_q <= even_parity(op1_d);
            par2_q <= even_parity(op2_d);
        end
    end

    assign s_opex_perr_o = valid_q &&
                           ((even_parity(op1_q) != par1_q) ||
                            (even_parity(op2_q) != par2_q));
`endif

    assign s_opex_op1_o     = op1_res;
    assign s_opex_op2_o     = op2_res;
    assign s_opex_rd_o      = rd_q;
    assign s_opex_ictrl_o   = ictrl_q;
    assign s_opex_f_o       = f_q;
    assign s_opex_payload_o = payload_q;
    assign s_opex_valid_o   = valid_q;

endmodule
